sample_buffer: RTL
==================

SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, buffer depth in samples; power of two, >= 2.
REQ-003 The block SHALL have parameter CNT_W, default 8, width of the drop and gap counters.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, sample present on in_data this cycle; no backpressure.
REQ-007 The block SHALL have port in_data, input, DATA_W, incoming counter sample.
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds the oldest buffered sample.
REQ-009 The block SHALL have port out_ready, input, 1, the consumer accepts out_data this cycle.
REQ-010 The block SHALL have port out_data, output, DATA_W, oldest buffered sample.
REQ-011 The block SHALL have port level, output, clog2(DEPTH)+1, current occupancy.
REQ-012 The block SHALL have port drop_cnt, output, CNT_W, number of samples dropped while full, saturating.
REQ-013 The block SHALL have port gap_err, output, 1, one-cycle pulse on a sequence discontinuity.
REQ-014 The block SHALL have port gap_cnt, output, CNT_W, number of discontinuities seen, saturating.

Function
REQ-015 The block SHALL treat a push as in_valid high while level < DEPTH, or while level = DEPTH and a pop occurs in the same cycle.
REQ-016 The block SHALL treat a pop as out_valid and out_ready both high.
REQ-017 The block SHALL drive out_valid = (level != 0), registered.
REQ-018 A sample pushed into an empty buffer SHALL appear on out_data with out_valid high on the next cycle (latency 1).
REQ-019 On simultaneous push and pop, level SHALL stay unchanged and FIFO order SHALL be kept.
REQ-020 When in_valid is high, level = DEPTH and there is no pop, the sample SHALL be discarded and drop_cnt incremented, holding at 2^CNT_W-1.
REQ-021 out_data and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-022 The gap checker SHALL inspect every in_valid sample, whether it is accepted or dropped.
REQ-023 The first in_valid sample after reset SHALL only set the expectation; no error.
REQ-024 Each later sample SHALL be compared with (previous sample + 1) mod 2^DATA_W; a mismatch SHALL pulse gap_err on the next cycle and increment gap_cnt, saturating.
REQ-025 The wrap from 2^DATA_W-1 (4095) to 0 SHALL NOT be flagged as a gap.
REQ-026 After a gap, the expectation SHALL resynchronise to the offending sample + 1.
REQ-027 Cycles with in_valid low SHALL NOT alter the expectation.
REQ-028 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap naturally.

Reset
REQ-029 While rst_n is low at a clk edge, the block SHALL force level = 0, out_valid = 0, pointers = 0, drop_cnt = 0, gap_cnt = 0, gap_err = 0, and clear the first-sample flag.
REQ-030 A reset mid-operation SHALL discard all buffered samples; inputs during the reset cycle SHALL be ignored.
REQ-031 out_data SHALL be don't-care while out_valid is low and needs no reset.

Structure
REQ-032 The constants DATA_W_DEF = 12, DEPTH_DEF = 8 and CNT_W_DEF = 8 SHALL live in the shared package sample_buf_pkg.
REQ-033 The sequence check SHALL be a sub-module, seq_gap_checker, with ports clk, rst_n, in_valid, in_data, gap_err, gap_cnt.
REQ-034 Storage SHALL be an inferred register array with no vendor primitives.

Verification
REQ-035 Reset, then push 0..5 on consecutive cycles with out_ready = 1 -> out_data is 0..5 in order, each one cycle after its push; level never exceeds 1; gap_cnt = 0.
REQ-036 out_ready = 0, push 0..9 -> level = 8, drop_cnt = 2; then drain -> out_data is 0..7.
REQ-037 Fill to level = 8, then push 8 with a pop in the same cycle -> level stays 8, drop_cnt unchanged, and 8 appears last.
REQ-038 Push 4094, 4095, 0, 1 -> no gap_err; then push 1, 3 -> two gap_err pulses, gap_cnt = 2.
REQ-039 Force 300 gaps -> gap_cnt saturates at 255; force 300 drops -> drop_cnt holds at 255.
REQ-040 Buffer at level = 5, assert rst_n = 0 for one cycle with in_valid high -> next cycle level = 0, out_valid = 0, counters = 0; the next sample sets no gap_err.

Source files
------------

// File: rtl/sample_buf_pkg.sv
// rtl/sample_buf_pkg.sv - shared default sizes for the sample buffer slice
package sample_buf_pkg;

   // Default sample width, buffer depth and counter width
   localparam int DATA_W_DEF = 12;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/seq_gap_checker.sv
// rtl/seq_gap_checker.sv - flags breaks in an incrementing counter sample stream
module seq_gap_checker
   import sample_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              gap_err,
   output logic [CNT_W-1:0]  gap_cnt
);

   logic              have_q;
   logic              have_d;
   logic [DATA_W-1:0] exp_q;
   logic [DATA_W-1:0] exp_d;
   logic              gap_err_q;
   logic              gap_err_d;
   logic [CNT_W-1:0]  gap_cnt_q;
   logic [CNT_W-1:0]  gap_cnt_d;
   logic              mismatch;

   // Only samples after the first one can be out of sequence; the
   // expectation always follows the latest sample so a gap resynchronises
   assign mismatch = in_valid && have_q && (in_data != exp_q);

   // Next-state for expectation, error pulse and saturating gap counter
   always_comb begin
      have_d    = have_q;
      exp_d     = exp_q;
      gap_err_d = mismatch;
      gap_cnt_d = gap_cnt_q;
      if (in_valid) begin
         have_d = 1'b1;
         exp_d  = in_data + DATA_W'(1);
      end
      if (mismatch && (gap_cnt_q != {CNT_W{1'b1}})) begin
         gap_cnt_d = gap_cnt_q + CNT_W'(1);
      end
   end

   // Checker state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         have_q    <= 1'b0;
         exp_q     <= '0;
         gap_err_q <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         have_q    <= have_d;
         exp_q     <= exp_d;
         gap_err_q <= gap_err_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign gap_err = gap_err_q;
   assign gap_cnt = gap_cnt_q;

endmodule

// File: rtl/sample_buffer.sv
// rtl/sample_buffer.sv - lossy sample FIFO with drop counting and sequence checking
module sample_buffer
   import sample_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       drop_cnt,
   output logic                   gap_err,
   output logic [CNT_W-1:0]       gap_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_d;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [CNT_W-1:0]  drop_cnt_q;
   logic [CNT_W-1:0]  drop_cnt_d;
   logic              full;
   logic              push;
   logic              pop;
   logic              drop;

   assign full = (level_q == LVL_W'(DEPTH));
   assign pop  = out_valid_q && out_ready;
   // A full buffer still accepts a sample when a slot frees in the same cycle
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && !push;

   // Pointer, occupancy, valid and drop-counter next state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      out_valid_d = (level_d != '0);
   end

   // Control registers with synchronous reset; buffered samples are discarded
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Sample storage; contents are meaningless until pointed at, so no reset
   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = out_valid_q;
   assign level     = level_q;
   assign drop_cnt  = drop_cnt_q;

   seq_gap_checker #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .gap_err  (gap_err),
      .gap_cnt  (gap_cnt)
   );

endmodule
